// File: rtl/grey_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grey_counter_pkg
//  Description : Shared types and helpers for the Gray counter family.
//                - state_e  : stream FSM states (PRIME, RUN, DONE)
//                - bin2grey : binary-to-Gray conversion, shared with the
//                             Gray encoder/decoder blocks
//  Revision    : 1.0  initial release
// ============================================================================
package grey_counter_pkg;

  // Widest operand the shared helper accepts; callers truncate to their N.
  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [MAX_W-1:0] bin2grey(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/grey_step_calc.sv
`default_nettype none
// ============================================================================
//  Module      : grey_step_calc
//  Description : Combinational next-count calculator for grey_counter_nbit.
//  Ports       : i_bin        current binary count
//                i_up         1 = increment, 0 = decrement
//                i_wrap       1 = wrap at range ends, 0 = saturate
//                o_next_bin   next binary count (held when saturating)
//                o_next_grey  Gray code of o_next_bin
//                o_at_end     count sits at the endpoint in direction i_up
//                o_wrap_evt   stepping now would wrap around
//  Revision    : 1.0  initial release
// ============================================================================
module grey_step_calc
  import grey_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] i_bin,
  input  logic         i_up,
  input  logic         i_wrap,
  output logic [N-1:0] o_next_bin,
  output logic [N-1:0] o_next_grey,
  output logic         o_at_end,
  output logic         o_wrap_evt
);

  logic [MAX_W-1:0] w_bin_ext;

  always_comb begin
    o_at_end   = i_up ? (&i_bin) : ~(|i_bin);
    o_wrap_evt = o_at_end & i_wrap;

    // N-bit modulo arithmetic provides the wrap-around for free; only the
    // saturating endpoint needs an explicit hold.
    if (o_at_end && !i_wrap) begin
      o_next_bin = i_bin;
    end else if (i_up) begin
      o_next_bin = i_bin + N'(1);
    end else begin
      o_next_bin = i_bin - N'(1);
    end

    w_bin_ext          = '0;
    w_bin_ext[N-1:0]   = o_next_bin;
    o_next_grey        = N'(bin2grey(w_bin_ext));
  end

endmodule
`default_nettype wire

// File: rtl/grey_counter_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : grey_counter_nbit
//  Description : Registered N-bit up/down counter offering each count and its
//                Gray code over a valid/ready stream; parallel load, wrap or
//                saturate, terminal-count flag and wrap pulse.
//  Ports       : i_clk, i_rst_n   clock, synchronous active-low reset
//                i_en, i_up       count enable, direction
//                i_wrap           wrap (1) or saturate (0) at range ends
//                i_load,
//                i_load_val       parallel load (priority over counting)
//                i_ready          downstream accepts current offer
//                o_valid          offer present (state RUN)
//                o_bin, o_grey    registered count and its Gray code
//                o_tc             terminal count (combinational)
//                o_wrapped        one-cycle pulse with a wrapped value
//  Revision    : 1.0  initial release
// ============================================================================
module grey_counter_nbit
  import grey_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_wrap,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [N-1:0] o_bin,
  output logic [N-1:0] o_grey,
  output logic         o_tc,
  output logic         o_wrapped
);

  state_e         state_q, state_d;
  logic [N-1:0]   bin_q, bin_d;
  logic [N-1:0]   grey_q, grey_d;
  logic           wrapped_q, wrapped_d;

  logic [N-1:0]     step_bin, step_grey;
  logic             at_end, wrap_evt;
  logic             xfer;
  logic [MAX_W-1:0] load_ext;

  grey_step_calc #(.N(N)) u_step (
    .i_bin       (bin_q),
    .i_up        (i_up),
    .i_wrap      (i_wrap),
    .o_next_bin  (step_bin),
    .o_next_grey (step_grey),
    .o_at_end    (at_end),
    .o_wrap_evt  (wrap_evt)
  );

  always_comb begin
    o_valid = (state_q == RUN);
    xfer    = o_valid & i_ready;

    load_ext        = '0;
    load_ext[N-1:0] = i_load_val;

    state_d   = state_q;
    bin_d     = bin_q;
    grey_d    = grey_q;
    wrapped_d = 1'b0;   // pulse lasts only the cycle the wrapped value appears

    if (i_load) begin
      // Load wins in every state; a coinciding transfer is simply consumed.
      state_d = RUN;
      bin_d   = i_load_val;
      grey_d  = N'(bin2grey(load_ext));
    end else begin
      case (state_q)
        PRIME: state_d = RUN;
        RUN: begin
          if (xfer && i_en) begin
            if (at_end && !i_wrap) begin
              state_d = DONE;
            end else begin
              bin_d     = step_bin;
              grey_d    = step_grey;
              wrapped_d = wrap_evt;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = PRIME;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= PRIME;
      bin_q     <= '0;
      grey_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      grey_q    <= grey_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign o_bin     = bin_q;
  assign o_grey    = grey_q;
  assign o_wrapped = wrapped_q;
  assign o_tc      = at_end;

endmodule
`default_nettype wire

// File: tb/tb_grey_counter_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grey_counter_nbit
//  Description : Self-checking bench for grey_counter_nbit (N = 4): directed
//                scenarios followed by randomized stimulus, all compared
//                against an integer reference model of the counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_grey_counter_nbit;

  localparam int N   = 4;
  localparam int TOP = (1 << N) - 1;

  logic         i_clk = 1'b0;
  logic         i_rst_n, i_en, i_up, i_wrap, i_load, i_ready;
  logic [N-1:0] i_load_val;
  logic         o_valid, o_tc, o_wrapped;
  logic [N-1:0] o_bin, o_grey;

  grey_counter_nbit #(.N(N)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_up       (i_up),
    .i_wrap     (i_wrap),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_bin      (o_bin),
    .o_grey     (o_grey),
    .o_tc       (o_tc),
    .o_wrapped  (o_wrapped)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Gray code of each 4-bit value, i.e. the reflected Gray sequence.
  int gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  // Reference model
  int m_bin     = 0;
  bit m_valid   = 1'b0;
  bit m_prime   = 1'b0;
  bit m_wr      = 1'b0;
  bit m_init    = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check o_tc, clock, advance model, check.
  task automatic cyc(input bit rst_n, input bit en, input bit up, input bit wrap,
                     input bit load, input int lv, input bit rdy);
    int n;
    i_rst_n    = rst_n;
    i_en       = en;
    i_up       = up;
    i_wrap     = wrap;
    i_load     = load;
    i_load_val = N'(lv);
    i_ready    = rdy;
    #1;
    if (m_init) check("tc", int'(o_tc), int'(up ? (m_bin == TOP) : (m_bin == 0)));
    @(posedge i_clk);
    if (!rst_n) begin
      m_bin = 0; m_valid = 0; m_prime = 1; m_wr = 0; m_init = 1;
    end else if (load) begin
      m_bin = lv % (TOP + 1); m_valid = 1; m_prime = 0; m_wr = 0;
    end else if (m_prime) begin
      m_prime = 0; m_valid = 1; m_wr = 0;
    end else if (m_valid && rdy && en) begin
      n = up ? m_bin + 1 : m_bin - 1;
      if (n < 0 || n > TOP) begin
        if (wrap) begin
          m_bin = (n + TOP + 1) % (TOP + 1);
          m_wr  = 1;
        end else begin
          m_valid = 0;
          m_wr    = 0;
        end
      end else begin
        m_bin = n;
        m_wr  = 0;
      end
    end else begin
      m_wr = 0;
    end
    #1;
    check("valid",   int'(o_valid),   int'(m_valid));
    check("bin",     int'(o_bin),     m_bin);
    check("grey",    int'(o_grey),    gseq[m_bin]);
    check("wrapped", int'(o_wrapped), int'(m_wr));
  endtask

  int exp_seq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    i_rst_n = 0; i_en = 0; i_up = 1; i_wrap = 1; i_load = 0;
    i_load_val = '0; i_ready = 0;

    // Reset then free-run
    cyc(0, 1, 1, 1, 0, 0, 1);
    check("reset_valid", int'(o_valid), 0);
    check("reset_bin",   int'(o_bin),   0);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 1, 1, 1, 0, 0, 1);
      check("free_valid", int'(o_valid), 1);
      check("free_grey",  int'(o_grey),  exp_seq[i]);
    end
    check("free_wrap_pulse", int'(o_wrapped), 1);

    // Advance to 5, then stall
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0, 0, 1);
    check("bp_start", int'(o_bin), 5);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 1, 0, 0, 0);
      check("bp_bin",  int'(o_bin),  5);
      check("bp_grey", int'(o_grey), 7);
    end
    cyc(1, 1, 1, 1, 0, 0, 1);
    check("bp_release", int'(o_bin), 6);

    // Saturate at 15
    cyc(1, 1, 1, 0, 1, 13, 1);
    check("sat_load", int'(o_bin), 13);
    cyc(1, 1, 1, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 0, 1);
    check("sat_15", int'(o_bin), 15);
    cyc(1, 1, 1, 0, 0, 0, 1);
    check("sat_done_valid", int'(o_valid), 0);
    check("sat_done_bin",   int'(o_bin),   15);
    cyc(1, 1, 0, 1, 0, 0, 1);
    check("sat_hold", int'(o_bin), 15);
    cyc(1, 1, 1, 0, 1, 2, 1);
    check("sat_reload_valid", int'(o_valid), 1);
    check("sat_reload_grey",  int'(o_grey),  3);

    // Down-count wrap
    cyc(1, 1, 0, 1, 1, 1, 1);
    cyc(1, 1, 0, 1, 0, 0, 1);
    check("down_0", int'(o_bin), 0);
    cyc(1, 1, 0, 1, 0, 0, 1);
    check("down_15",      int'(o_bin),     15);
    check("down_15_grey", int'(o_grey),    8);
    check("down_wrapped", int'(o_wrapped), 1);

    // Load during transfer with counting disabled
    cyc(1, 0, 1, 1, 1, 9, 1);
    cyc(1, 0, 1, 1, 1, 4, 1);
    check("ldx_bin",  int'(o_bin),  4);
    check("ldx_grey", int'(o_grey), 6);
    cyc(1, 0, 1, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 1);
    check("ldx_repeat", int'(o_bin), 4);

    // Reset mid-run
    cyc(1, 1, 1, 1, 1, 10, 1);
    cyc(0, 1, 1, 1, 1, 7, 1);
    check("mid_rst_valid",   int'(o_valid),   0);
    check("mid_rst_bin",     int'(o_bin),     0);
    check("mid_rst_grey",    int'(o_grey),    0);
    check("mid_rst_wrapped", int'(o_wrapped), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 39) != 0,
          $urandom_range(0, 3) != 0,
          1'($urandom),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0,
          int'($urandom_range(0, TOP)),
          $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
